// File: rtl/energy_accumulator.sv
// energy_accumulator: streams VECTOR_WIDTH local fields h_j and accumulates E = sum_j sigma_j*h_j.
// Define ENERGY_ABORT_EN to add abort_i, which cancels an evaluation from ACCUM or DONE.
module energy_accumulator #(
    parameter int VECTOR_WIDTH = 8,
    parameter int N = 4,
    parameter int DATA_WIDTH = N + $clog2(VECTOR_WIDTH) + 1,
    parameter int ACC_WIDTH = DATA_WIDTH + $clog2(VECTOR_WIDTH),
    localparam int IW = $clog2(VECTOR_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef ENERGY_ABORT_EN
    input  logic                        abort_i,
`endif
    input  logic                        start_i,
    input  logic [VECTOR_WIDTH-1:0]     sigma_i,
    input  logic                        h_valid_i,
    output logic                        h_ready_o,
    input  logic signed [DATA_WIDTH-1:0] h_data_i,
    output logic [IW-1:0]               col_idx_o,
    output logic signed [ACC_WIDTH-1:0] energy_o,
    output logic                        energy_valid_o,
    input  logic                        energy_ready_i,
    output logic                        busy_o
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                      r_state;
    logic [VECTOR_WIDTH-1:0]     r_sigma;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [IW-1:0]               r_col;
    logic                        r_h_ready;
    logic                        r_valid;
    logic                        r_busy;

    logic                        w_abort;
    logic                        w_last;
    logic signed [ACC_WIDTH-1:0] w_h_ext;
    logic signed [ACC_WIDTH-1:0] w_next;

`ifdef ENERGY_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last  = r_col == IW'(VECTOR_WIDTH - 1);
    assign w_h_ext = {{(ACC_WIDTH-DATA_WIDTH){h_data_i[DATA_WIDTH-1]}}, h_data_i};
    assign w_next  = r_sigma[r_col] ? r_acc + w_h_ext : r_acc - w_h_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sigma   <= '0;
            r_acc     <= '0;
            r_col     <= '0;
            r_h_ready <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_state   <= ACCUM;
                    r_sigma   <= sigma_i;
                    r_acc     <= '0;
                    r_col     <= '0;
                    r_h_ready <= 1'b1;
                    r_busy    <= 1'b1;
                end
                ACCUM: if (w_abort) begin
                    r_state   <= IDLE;
                    r_acc     <= '0;
                    r_col     <= '0;
                    r_h_ready <= 1'b0;
                    r_busy    <= 1'b0;
                end else if (h_valid_i) begin
                    r_acc <= w_next;
                    r_col <= w_last ? '0 : r_col + IW'(1);
                    if (w_last) begin
                        r_state   <= DONE;
                        r_h_ready <= 1'b0;
                        r_valid   <= 1'b1;
                    end
                end
                DONE: if (w_abort) begin
                    r_state <= IDLE;
                    r_acc   <= '0;
                    r_col   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end else if (energy_ready_i) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_h_ready <= 1'b0;
                    r_valid   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign h_ready_o      = r_h_ready;
    assign energy_valid_o = r_valid;
    assign busy_o         = r_busy;
    assign col_idx_o      = r_col;
    assign energy_o       = r_acc;
endmodule

// File: tb/tb_energy_accumulator.sv
// tb_energy_accumulator: table-driven and scoreboarded checks of energy_accumulator (VECTOR_WIDTH=8).
module tb_energy_accumulator;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [7:0]        sigma_i = '0;
    logic              h_valid_i = 1'b0;
    logic              h_ready_o;
    logic [7:0]        h_data_i = '0;
    logic [2:0]        col_idx_o;
    logic signed [10:0] energy_o;
    logic              energy_valid_o;
    logic              energy_ready_i = 1'b0;
    logic              busy_o;
`ifdef ENERGY_ABORT_EN
    logic              abort_i = 1'b0;
`endif

    energy_accumulator dut (
        .clk(clk),
        .rst(rst),
`ifdef ENERGY_ABORT_EN
        .abort_i(abort_i),
`endif
        .start_i(start_i),
        .sigma_i(sigma_i),
        .h_valid_i(h_valid_i),
        .h_ready_o(h_ready_o),
        .h_data_i(h_data_i),
        .col_idx_o(col_idx_o),
        .energy_o(energy_o),
        .energy_valid_o(energy_valid_o),
        .energy_ready_i(energy_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      sigma;
        logic [7:0][7:0] h;
        bit              tog;
        int              hold;
        bit              hs_start;
        int              exp;
    } vec_t;

    int total = 0;
    int passed = 0;
    int exp_q[$];
    vec_t tbl[5];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int model(input logic [7:0] s, input logic [7:0][7:0] h);
        int e = 0;
        for (int j = 0; j < 8; j++) begin
            int hv = int'($signed(h[j]));
            e += s[j] ? hv : -hv;
        end
        return e;
    endfunction

    task automatic feed(input logic [7:0][7:0] h, input int cnt, input bit tog);
        for (int j = 0; j < cnt; j++) begin
            h_valid_i = 1'b1;
            h_data_i  = h[j];
            check("col_idx", int'(col_idx_o), j);
            check("h_ready_accum", int'(h_ready_o), 1);
            check("valid_in_accum", int'(energy_valid_o), 0);
            @(negedge clk);
            if (tog) begin
                h_valid_i = 1'b0;
                h_data_i  = ~h[j];
                @(negedge clk);
                check("col_idx_hold", int'(col_idx_o), (j + 1) % 8);
            end
        end
        h_valid_i = 1'b0;
    endtask

    task automatic collect(input int hold, input bit hs_start, input bit immediate);
        int n = 0;
        int e;
        while (!energy_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", int'(energy_valid_o), 1);
        if (immediate) check("latency", n, 0);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            e = 0;
        end else e = exp_q.pop_front();
        check("energy", int'(energy_o), e);
        check("col_wrap", int'(col_idx_o), 0);
        check("h_ready_done", int'(h_ready_o), 0);
        check("busy_done", int'(busy_o), 1);
        for (int k = 0; k < hold; k++) begin
            if (k == 2) begin
                start_i = 1'b1;
                sigma_i = 8'h33;
            end
            @(negedge clk);
            start_i = 1'b0;
            check("hold_valid", int'(energy_valid_o), 1);
            check("hold_energy", int'(energy_o), e);
        end
        energy_ready_i = 1'b1;
        start_i = hs_start;
        @(negedge clk);
        energy_ready_i = 1'b0;
        start_i = 1'b0;
        check("idle_valid", int'(energy_valid_o), 0);
        check("idle_busy", int'(busy_o), 0);
        check("idle_h_ready", int'(h_ready_o), 0);
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        sigma_i = v.sigma;
        start_i = 1'b1;
        exp_q.push_back(v.exp);
        @(negedge clk);
        start_i = 1'b0;
        sigma_i = ~v.sigma;
        feed(v.h, 8, v.tog);
        collect(v.hold, v.hs_start, !v.tog);
    endtask

    initial begin
        vec_t r;
        tbl[0] = '{8'hFF, {8{8'd3}}, 1'b0, 0, 1'b0, 24};
        tbl[1] = '{8'h0F, {8{8'd5}}, 1'b0, 0, 1'b0, 0};
        tbl[2] = '{8'h00, {8{8'hC0}}, 1'b1, 0, 1'b0, 512};
        tbl[3] = '{8'h81, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 5, 1'b1, -18};
        tbl[4] = '{8'h5A, {8'hC0, 8'h3F, 8'hFF, 8'h00, 8'h14, 8'hFD, 8'h0A, 8'hF9}, 1'b0, 2, 1'b0, 168};

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy_o), 0);
        check("rst_valid", int'(energy_valid_o), 0);
        check("rst_h_ready", int'(h_ready_o), 0);
        check("rst_col", int'(col_idx_o), 0);
        check("rst_energy", int'(energy_o), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start", int'(busy_o), 0);

        for (int i = 0; i < 5; i++) run(tbl[i]);

        for (int i = 0; i < 4; i++) begin
            r.sigma = 8'($urandom);
            for (int j = 0; j < 8; j++) begin
                int x = int'($urandom_range(127)) - 64;
                r.h[j] = x[7:0];
            end
            r.tog = 1'($urandom_range(1));
            r.hold = int'($urandom_range(3));
            r.hs_start = 1'b0;
            r.exp = model(r.sigma, r.h);
            run(r);
        end

        @(negedge clk);
        sigma_i = 8'hFF;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        feed({8{8'd1}}, 3, 1'b0);
        check("pre_rst_energy", int'(energy_o), 3);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_h_ready", int'(h_ready_o), 0);
        check("async_rst_col", int'(col_idx_o), 0);
        check("async_rst_energy", int'(energy_o), 0);
        check("async_rst_valid", int'(energy_valid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", int'(busy_o), 0);
        r = '{8'hFF, {8{8'd1}}, 1'b0, 0, 1'b0, 8};
        run(r);

`ifdef ENERGY_ABORT_EN
        @(negedge clk);
        sigma_i = 8'hFF;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        feed({8{8'd7}}, 4, 1'b0);
        abort_i = 1'b1;
        h_valid_i = 1'b1;
        h_data_i = 8'd7;
        @(negedge clk);
        abort_i = 1'b0;
        h_valid_i = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_col", int'(col_idx_o), 0);
        check("abort_energy", int'(energy_o), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_valid", int'(energy_valid_o), 0);
        end
        r = '{8'hFF, {8{8'd2}}, 1'b0, 0, 1'b0, 16};
        run(r);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
